// File: rtl/fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// fc_argmax_classifier
//
// Purpose:
//   Sits after the binarized fully-connected stage. When valid_in pulses, the
//   ten class scores are captured into a local bank. They are then scanned
//   serially, one compare per clock, to find:
//     - the winning class index (argmax, lowest index wins on ties),
//     - the winning score,
//     - the margin between the winner and the runner-up.
//   The result is published with a one-cycle valid_out pulse. busy is high
//   while a scan is in flight.
//
// Ports:
//   clk                    in   rising-edge clock
//   rst                    in   asynchronous active-high reset
//   valid_in               in   one-cycle pulse; fc_in_* valid in that cycle
//   fc_in_1 .. fc_in_10    in   unsigned scores for digits 0..9
//   busy                   out  high while in SCAN or DONE
//   valid_out              out  one-cycle pulse; result outputs valid
//   class_out              out  predicted digit 0..9
//   max_score              out  winning score
//   margin                 out  winning score minus runner-up score
//   conf_low               out  margin below CONF_MARGIN (ARGMAX_CONF_EN only)
//
// Configuration:
//   Define ARGMAX_CONF_EN to add the conf_low output, the CONF_MARGIN
//   parameter and the low-confidence flag logic.
// -----------------------------------------------------------------------------
module fc_argmax_classifier #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 9,
    parameter int IDX_W       = 4
`ifdef ARGMAX_CONF_EN
    ,
    parameter logic [SCORE_W-1:0] CONF_MARGIN = 9'd8
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic [SCORE_W-1:0] fc_in_1,
    input  logic [SCORE_W-1:0] fc_in_2,
    input  logic [SCORE_W-1:0] fc_in_3,
    input  logic [SCORE_W-1:0] fc_in_4,
    input  logic [SCORE_W-1:0] fc_in_5,
    input  logic [SCORE_W-1:0] fc_in_6,
    input  logic [SCORE_W-1:0] fc_in_7,
    input  logic [SCORE_W-1:0] fc_in_8,
    input  logic [SCORE_W-1:0] fc_in_9,
    input  logic [SCORE_W-1:0] fc_in_10,
    output logic               busy,
    output logic               valid_out,
    output logic [IDX_W-1:0]   class_out,
    output logic [SCORE_W-1:0] max_score,
    output logic [SCORE_W-1:0] margin
`ifdef ARGMAX_CONF_EN
    ,
    output logic               conf_low
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [1:0]         state_r;
    logic [IDX_W-1:0]   ptr_r;
    logic [SCORE_W-1:0] score_r [0:NUM_CLASSES-1];
    logic [SCORE_W-1:0] best_r;
    logic [SCORE_W-1:0] second_r;
    logic [IDX_W-1:0]   best_idx_r;
    logic               busy_r;
    logic               valid_out_r;
    logic [IDX_W-1:0]   class_r;
    logic [SCORE_W-1:0] max_score_r;
    logic [SCORE_W-1:0] margin_r;
    logic [SCORE_W-1:0] score_sel_s;
    logic [SCORE_W-1:0] diff_s;
`ifdef ARGMAX_CONF_EN
    logic               conf_low_r;
`endif

    // Select the score under the scan pointer; out-of-range pointers read zero.
    always_comb begin
        score_sel_s = {SCORE_W{1'b0}};
        case (ptr_r)
            4'd0:    score_sel_s = score_r[0];
            4'd1:    score_sel_s = score_r[1];
            4'd2:    score_sel_s = score_r[2];
            4'd3:    score_sel_s = score_r[3];
            4'd4:    score_sel_s = score_r[4];
            4'd5:    score_sel_s = score_r[5];
            4'd6:    score_sel_s = score_r[6];
            4'd7:    score_sel_s = score_r[7];
            4'd8:    score_sel_s = score_r[8];
            4'd9:    score_sel_s = score_r[9];
            default: score_sel_s = {SCORE_W{1'b0}};
        endcase
    end

    // second never exceeds best, so this difference cannot wrap.
    assign diff_s = best_r - second_r;

    // Frame capture, serial argmax scan and result publication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            best_r      <= {SCORE_W{1'b0}};
            second_r    <= {SCORE_W{1'b0}};
            best_idx_r  <= {IDX_W{1'b0}};
            busy_r      <= 1'b0;
            valid_out_r <= 1'b0;
            class_r     <= {IDX_W{1'b0}};
            max_score_r <= {SCORE_W{1'b0}};
            margin_r    <= {SCORE_W{1'b0}};
`ifdef ARGMAX_CONF_EN
            conf_low_r  <= 1'b0;
`endif
            for (int i = 0; i < NUM_CLASSES; i++) begin
                score_r[i] <= {SCORE_W{1'b0}};
            end
        end else begin
            valid_out_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // Scores are only sampled here; valid_in during a scan is ignored.
                    if (valid_in) begin
                        score_r[0]  <= fc_in_1;
                        score_r[1]  <= fc_in_2;
                        score_r[2]  <= fc_in_3;
                        score_r[3]  <= fc_in_4;
                        score_r[4]  <= fc_in_5;
                        score_r[5]  <= fc_in_6;
                        score_r[6]  <= fc_in_7;
                        score_r[7]  <= fc_in_8;
                        score_r[8]  <= fc_in_9;
                        score_r[9]  <= fc_in_10;
                        best_r      <= fc_in_1;
                        best_idx_r  <= {IDX_W{1'b0}};
                        second_r    <= {SCORE_W{1'b0}};
                        ptr_r       <= {{(IDX_W-1){1'b0}}, 1'b1};
                        state_r     <= SCAN;
                        busy_r      <= 1'b1;
                    end
                end
                SCAN: begin
                    // Strict compares keep the lowest index on ties and let
                    // the tied value fall into second, giving margin 0.
                    if (score_sel_s > best_r) begin
                        second_r   <= best_r;
                        best_r     <= score_sel_s;
                        best_idx_r <= ptr_r;
                    end else if (score_sel_s > second_r) begin
                        second_r   <= score_sel_s;
                    end
                    if (ptr_r == LAST_IDX) begin
                        state_r <= DONE;
                    end else begin
                        ptr_r   <= ptr_r + 1'b1;
                    end
                end
                DONE: begin
                    class_r     <= best_idx_r;
                    max_score_r <= best_r;
                    margin_r    <= diff_s;
`ifdef ARGMAX_CONF_EN
                    conf_low_r  <= (diff_s < CONF_MARGIN);
`endif
                    valid_out_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign valid_out = valid_out_r;
    assign class_out = class_r;
    assign max_score = max_score_r;
    assign margin    = margin_r;
`ifdef ARGMAX_CONF_EN
    assign conf_low  = conf_low_r;
`endif

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_fc_argmax_classifier
//
// Directed self-checking bench for fc_argmax_classifier. Inputs are driven and
// outputs sampled on the falling clock edge. Expected values are hand-computed
// from the score vectors. Define ARGMAX_CONF_EN to also check conf_low.
// -----------------------------------------------------------------------------
module tb_fc_argmax_classifier;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic [8:0] fc [10];
    logic       busy;
    logic       valid_out;
    logic [3:0] class_out;
    logic [8:0] max_score;
    logic [8:0] margin;
`ifdef ARGMAX_CONF_EN
    logic       conf_low;
`endif

    int errors;
    int checks;
    int s [10];

    fc_argmax_classifier dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .fc_in_1   (fc[0]),
        .fc_in_2   (fc[1]),
        .fc_in_3   (fc[2]),
        .fc_in_4   (fc[3]),
        .fc_in_5   (fc[4]),
        .fc_in_6   (fc[5]),
        .fc_in_7   (fc[6]),
        .fc_in_8   (fc[7]),
        .fc_in_9   (fc[8]),
        .fc_in_10  (fc[9]),
        .busy      (busy),
        .valid_out (valid_out),
        .class_out (class_out),
        .max_score (max_score),
        .margin    (margin)
`ifdef ARGMAX_CONF_EN
        ,
        .conf_low  (conf_low)
`endif
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive junk onto the score inputs; the DUT must not sample it.
    task automatic scramble();
        for (int i = 0; i < 10; i++) fc[i] = 9'h1FF;
    endtask

    // Called at a falling edge: present scores with valid_in for one cycle.
    task automatic pulse(input int v [10]);
        for (int i = 0; i < 10; i++) fc[i] = 9'(v[i]);
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        scramble();
    endtask

    // Called at the falling edge just after the accepting edge. Checks the
    // 10 busy cycles, optionally pokes valid_in at cycle inj, then checks the
    // result cycle and stays on it.
    task automatic expect_result(input string tag, input int cls, input int mx,
                                 input int mg, input int inj);
        for (int i = 0; i < 10; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_vout_early"}, {31'd0, valid_out}, 32'd0);
            if (i == inj) begin
                for (int k = 0; k < 10; k++) fc[k] = 9'd399;
                fc[5] = 9'd400;
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
            valid_in = 1'b0;
            scramble();
        end
        check({tag, "_vout"}, {31'd0, valid_out}, 32'd1);
        check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_class"}, {28'd0, class_out}, 32'(cls));
        check({tag, "_max"}, {23'd0, max_score}, 32'(mx));
        check({tag, "_margin"}, {23'd0, margin}, 32'(mg));
    endtask

    // After the result cycle: pulse must be one cycle, results must hold.
    task automatic expect_hold(input string tag, input int cls, input int mg);
        @(negedge clk);
        check({tag, "_vout_1cyc"}, {31'd0, valid_out}, 32'd0);
        check({tag, "_class_hold"}, {28'd0, class_out}, 32'(cls));
        check({tag, "_margin_hold"}, {23'd0, margin}, 32'(mg));
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        valid_in = 1'b0;
        scramble();

        // Reset asserted asynchronously mid-cycle, then idle.
        #12;
        rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_vout", {31'd0, valid_out}, 32'd0);
        check("rst_class", {28'd0, class_out}, 32'd0);
        check("rst_max", {23'd0, max_score}, 32'd0);
        check("rst_margin", {23'd0, margin}, 32'd0);
`ifdef ARGMAX_CONF_EN
        check("rst_conf", {31'd0, conf_low}, 32'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_vout", {31'd0, valid_out}, 32'd0);
            check("idle_busy", {31'd0, busy}, 32'd0);
        end

        // Distinct scores: max 310 at digit 3, runner-up 200.
        s = '{100, 120, 90, 310, 50, 60, 70, 80, 200, 10};
        pulse(s);
        expect_result("distinct", 3, 310, 110, -1);
        expect_hold("distinct", 3, 110);

        // Tie at digits 2 and 7: lowest index wins, margin 0.
        s = '{100, 100, 250, 100, 100, 100, 100, 250, 100, 100};
        pulse(s);
        expect_result("tie", 2, 250, 0, -1);
        expect_hold("tie", 2, 0);

        // All equal.
        s = '{200, 200, 200, 200, 200, 200, 200, 200, 200, 200};
        pulse(s);
        expect_result("equal", 0, 200, 0, -1);
        expect_hold("equal", 0, 0);

        // Maximum at last position.
        s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 400};
        pulse(s);
        expect_result("last", 9, 400, 400, -1);
        expect_hold("last", 9, 400);

        // Maximum at first position, runner-up one below.
        s = '{400, 399, 399, 399, 399, 399, 399, 399, 399, 399};
        pulse(s);
        expect_result("first", 0, 400, 1, -1);
        expect_hold("first", 0, 1);

        // Second valid_in 4 cycles into the scan is ignored.
        s = '{10, 20, 30, 40, 50, 60, 70, 300, 90, 100};
        pulse(s);
        expect_result("busyrej", 7, 300, 200, 4);
        // Back-to-back: next frame offered in the valid_out cycle.
        s = '{5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
        pulse(s);
        expect_result("b2b", 9, 14, 1, -1);
        expect_hold("b2b", 9, 1);

        // Reset pulsed mid-scan: no result for the aborted frame.
        s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 390};
        pulse(s);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_margin", {23'd0, margin}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("midrst_no_vout", {31'd0, valid_out}, 32'd0);
        end

        // Next frame processed normally; margin 5 (low confidence).
        s = '{100, 100, 100, 100, 105, 100, 100, 100, 100, 100};
        pulse(s);
        expect_result("m5", 4, 105, 5, -1);
`ifdef ARGMAX_CONF_EN
        check("m5_conf", {31'd0, conf_low}, 32'd1);
`endif
        expect_hold("m5", 4, 5);

        // Margin 8: exactly at threshold, not low confidence.
        s = '{100, 100, 100, 100, 100, 100, 108, 100, 100, 100};
        pulse(s);
        expect_result("m8", 6, 108, 8, -1);
`ifdef ARGMAX_CONF_EN
        check("m8_conf", {31'd0, conf_low}, 32'd0);
`endif
        expect_hold("m8", 6, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
- Downstream of the binarized 400-input fully-connected stage; consumes its ten 9-bit popcount scores when the FC valid pulse fires.
- Serially scans the scores, one per cycle, and produces the predicted digit (argmax), the winning score and the best-minus-second margin.
- Adds a one-cycle result pulse and a busy flag for the top-level result/UART path.

Parameters:
- NUM_CLASSES, 10, number of scores scanned (fixed at 10 by the port list; kept for counter sizing).
- SCORE_W, 9, width of each score; 0..400 fits.
- IDX_W, 4, width of the class index.
- CONF_MARGIN, 9'd8, threshold used only when ARGMAX_CONF_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  one-cycle pulse; fc_in_* are valid in that cycle.
- fc_in_1 .. fc_in_10  in  SCORE_W each  unsigned scores for digits 0..9 (fc_in_1 is digit 0).
- busy  out  1  high while a scan is in progress (SCAN or DONE state).
- valid_out  out  1  one-cycle pulse; result outputs are valid in that cycle.
- class_out  out  IDX_W  predicted digit, 0..9.
- max_score  out  SCORE_W  winning score.
- margin  out  SCORE_W  max_score minus second-highest score.
- conf_low  out  1  present only with ARGMAX_CONF_EN.

Behaviour:
- Reset (asynchronous, rst=1):
  - State goes to IDLE; the pointer and internal registers clear.
  - busy=0, valid_out=0, class_out=0, max_score=0, margin=0, conf_low=0.
  - Reset mid-scan aborts the scan; no valid_out is produced for that frame.
- FSM IDLE -> SCAN -> DONE -> IDLE.
- IDLE:
  - On valid_in=1, latch all ten scores into a score register bank.
  - Initialise best=score[0], best_idx=0, second=0, ptr=1.
  - Go to SCAN.
- SCAN (one compare per cycle):
  - If score[ptr] > best: second<=best, best<=score[ptr], best_idx<=ptr.
  - Else if score[ptr] > second: second<=score[ptr].
  - Comparisons are strict. On ties the lowest index wins and second takes the tied value, so margin=0.
  - When ptr==NUM_CLASSES-1, go to DONE; otherwise ptr<=ptr+1.
- DONE:
  - class_out<=best_idx, max_score<=best, margin<=best-second (never negative).
  - valid_out<=1 for exactly one cycle; return to IDLE.
- Latency: if valid_in is sampled at edge T, valid_out is high in the cycle after edge T+NUM_CLASSES (10 clocks).
- Result outputs hold their value until the next DONE.
- busy goes high in the cycle after valid_in is accepted. It goes low in the same cycle valid_out is high (state back to IDLE).
- valid_in while busy=1 is ignored: no relatch and no disturbance to the scan in progress. The FC stage delivers at most one pulse per 26 cycles, so this does not occur in normal flow.
- valid_in arriving in the same cycle valid_out is high (state IDLE) is accepted, so back-to-back frames are legal.
- fc_in_* are not sampled outside the valid_in cycle.

Optional Feature:
- Macro: ARGMAX_CONF_EN.
- Defined:
  - conf_low port exists.
  - In DONE, conf_low<=(best-second < CONF_MARGIN), updated together with the other results and held until the next DONE.
  - Reset value 0.
- Undefined: conf_low port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 asserted asynchronously mid-cycle, then released with no valid_in.
  - Required: all outputs 0, busy=0, valid_out never asserts.
- Distinct scores:
  - Stimulus: scores 100,120,90,310,50,60,70,80,200,10.
  - Required: exactly 10 clocks later, valid_out=1 for one cycle; class_out=3, max_score=310, margin=110; busy high for the 10 cycles in between.
- Tie and all-equal:
  - Stimulus: scores 250 at digits 2 and 7, all others 100.
  - Required: class_out=2, max_score=250, margin=0.
  - Stimulus: all ten scores 200.
  - Required: class_out=0, margin=0.
- Boundary positions:
  - Stimulus: maximum 400 at digit 9, others 0.
  - Required: class_out=9, margin=400.
  - Stimulus: maximum 400 at digit 0, others 399.
  - Required: class_out=0, margin=1.
- Busy rejection and back-to-back:
  - Stimulus: second valid_in 4 cycles into a scan.
  - Required: the first frame's result is unaffected.
  - Stimulus: a new valid_in in the valid_out cycle.
  - Required: the new frame is accepted; its result follows 10 clocks later.
- Reset mid-scan and confidence:
  - Stimulus: rst pulsed during SCAN.
  - Required: no valid_out; the next frame is processed normally.
  - With ARGMAX_CONF_EN, scores giving margin 5 -> conf_low=1; margin 8 -> conf_low=0.
